alu_bitserial_seq: RTL and testbench

//  Bit-serial sequencer driving the 1-bit ALU slice (AND/OR/SUM result via mux4x1).

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu1_slice.sv | 30 +++
 rtl/mux4x1.sv | 13 +
 rtl/alu_bitserial_seq.sv | 118 +++++++++++
 tb/tb_alu_bitserial_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: opcodes and sequencer states.
// The 1-bit slice's mux inputs are ordered to match the opcode values below.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu1_slice.sv
// Combinational 1-bit ALU slice: AND, OR and full-adder sum selected by opcode.
// ADD and SUB both take the sum; the sequencer inverts bi and seeds the carry for SUB.
module alu1_slice (
    input  logic       ai,
    input  logic       bi,
    input  logic       ci,
    input  logic [1:0] op,
    output logic       res_bit,
    output logic       cout
);

    logic and_b;
    logic or_b;
    logic sum_b;

    assign and_b = ai & bi;
    assign or_b  = ai | bi;
    assign sum_b = ai ^ bi ^ ci;
    assign cout  = (ai & bi) | (ai & ci) | (bi & ci);

    mux4x1 u_mux (
        .d0  (and_b),
        .d1  (or_b),
        .d2  (sum_b),
        .d3  (sum_b),
        .sel (op),
        .y   (res_bit)
    );

endmodule

// File: rtl/mux4x1.sv
// Plain 4-to-1 single-bit multiplexer.
module mux4x1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: latches operands on start, feeds the 1-bit slice LSB first,
// reassembles the result and reports carry/overflow/zero with a one-cycle done pulse.
module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             is_sub;
    logic             is_arith;
    logic             bi;
    logic             res_bit;
    logic             cout;
    logic             last;

    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = (op_q == OP_ADD) || is_sub;
    assign bi       = b_sh[0] ^ is_sub;
    assign r_next   = {res_bit, r_sh[WIDTH-1:1]};
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    alu1_slice u_slice (
        .ai      (a_sh[0]),
        .bi      (bi),
        .ci      (c),
        .op      (op_q),
        .res_bit (res_bit),
        .cout    (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (last)  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // On the final bit, c is still the carry into the MSB, so overflow is c ^ cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            op_q      <= OP_AND;
            cnt       <= '0;
            c         <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_q <= op;
                        cnt  <= '0;
                        c    <= (op == OP_SUB);
                    end
                end
                ST_RUN: begin
                    r_sh <= r_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    if (is_arith)
                        c <= cout;
                    if (last) begin
                        result    <= r_next;
                        carry_out <= is_arith & cout;
                        overflow  <= is_arith & (c ^ cout);
                        zero      <= (r_next == '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_alu_bitserial_seq;

    localparam int WIDTH = 32;
    localparam logic [1:0] T_AND = 2'b00;
    localparam logic [1:0] T_OR  = 2'b01;
    localparam logic [1:0] T_ADD = 2'b10;
    localparam logic [1:0] T_SUB = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] prevResult = '0;

    alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t refModel(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t         e;
        logic [WIDTH:0] s;
        e = '0;
        s = '0;
        case (o)
            T_AND: e.r = x & y;
            T_OR:  e.r = x | y;
            T_ADD: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[WIDTH-1:0];
                e.c = s[WIDTH];
                e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
            end
            default: begin
                s   = {1'b0, x} + {1'b0, ~y} + 1;
                e.r = s[WIDTH-1:0];
                e.c = s[WIDTH];
                e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
            end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op and follows it to done; pulseAt >= 0 re-pulses start that many cycles into RUN.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input int pulseAt);
        exp_t e;
        int   lat;
        e = refModel(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        checkOutput({tag, "_busy"}, WIDTH'(busy), WIDTH'(1));
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == 5)
                checkOutput({tag, "_held"}, result, prevResult);
            if (lat == pulseAt) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, WIDTH'(lat), WIDTH'(WIDTH));
        checkOutput({tag, "_result"}, result, e.r);
        checkOutput({tag, "_carry"}, WIDTH'(carry_out), WIDTH'(e.c));
        checkOutput({tag, "_ovf"}, WIDTH'(overflow), WIDTH'(e.v));
        checkOutput({tag, "_zero"}, WIDTH'(zero), WIDTH'(e.z));
        prevResult = e.r;
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, WIDTH'(done), WIDTH'(0));
        checkOutput({tag, "_idle"}, WIDTH'(busy), WIDTH'(0));
        checkOutput({tag, "_after"}, result, e.r);
    endtask

    initial begin
        int doneSeen;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", WIDTH'(busy), WIDTH'(0));
        checkOutput("rst_done", WIDTH'(done), WIDTH'(0));
        checkOutput("rst_result", result, '0);
        checkOutput("rst_flags", WIDTH'({carry_out, overflow, zero}), WIDTH'(0));
        rst_n = 1'b1;

        applyStimulus("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'h1, -1);
        applyStimulus("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'h1, -1);
        applyStimulus("sub_neg", T_SUB, 32'd5, 32'd7, -1);
        applyStimulus("sub_pos", T_SUB, 32'd7, 32'd5, -1);
        applyStimulus("and", T_AND, 32'hF0F0_A5A5, 32'h0FF0_FF00, -1);
        applyStimulus("or", T_OR, 32'hF0F0_A5A5, 32'h0FF0_FF00, -1);
        applyStimulus("sub_ovf", T_SUB, 32'h8000_0000, 32'h1, -1);
        applyStimulus("ignore_start", T_ADD, 32'h1234_5678, 32'h1111_1111, 10);

        // Reset 16 cycles into RUN must clear everything at once and suppress done.
        @(negedge clk);
        op = T_ADD; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", WIDTH'(busy), WIDTH'(0));
        checkOutput("midrst_done", WIDTH'(done), WIDTH'(0));
        checkOutput("midrst_result", result, '0);
        checkOutput("midrst_flags", WIDTH'({carry_out, overflow, zero}), WIDTH'(0));
        prevResult = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("midrst_nodone", WIDTH'(doneSeen), WIDTH'(0));
        applyStimulus("post_rst", T_SUB, 32'hDEAD_BEEF, 32'h0BAD_F00D, -1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("rand%0d", i), 2'($urandom), $urandom, $urandom, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
